// File: rtl/data_mem_responder_if.sv
// Memory-control bus between the multi-cycle datapath (master) and the data memory responder.
// The master holds its strobes, address and store data until it sees ready.
interface data_mem_responder_if #(
  parameter int unsigned AW = 32
) ();
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          ready;
  logic          busy;
  logic          err;

  modport master (
    output mem_rd, mem_wr, addr, wr_data,
    input  rd_data, ready, busy, err
  );

  modport slave (
    input  mem_rd, mem_wr, addr, wr_data,
    output rd_data, ready, busy, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed access latency and a one-cycle ready/err pulse.
// Requests are latched in IDLE; the access commits on the edge that enters DONE.
module data_mem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 2,
  parameter int unsigned AW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_responder_if.slave bus_io
);

  localparam int unsigned CW   = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-3:0] WordLimit = (AW-2)'(DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          op_rd_q, op_rd_d;
  logic          op_wr_q, op_wr_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH];
  logic          mem_we;
  logic          commit;

  // With LAT=0 the commit happens on the accepting edge, so the live inputs stand in for the latch.
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_rd, req_wr, req_err;
  logic [IdxW-1:0] req_idx;

  always_comb begin
    if (state_q == StIdle) begin
      req_addr  = bus_io.addr;
      req_wdata = bus_io.wr_data;
      req_rd    = bus_io.mem_rd;
      req_wr    = bus_io.mem_wr;
    end else begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_rd    = op_rd_q;
      req_wr    = op_wr_q;
    end
    req_idx = req_addr[IdxW+1:2];
    req_err = (req_addr[1:0] != 2'b00) || (req_addr[AW-1:2] >= WordLimit) || (req_rd && req_wr);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_rd_d   = op_rd_q;
    op_wr_d   = op_wr_q;
    rd_data_d = rd_data_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    commit    = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus_io.mem_rd || bus_io.mem_wr) begin
          addr_d  = bus_io.addr;
          wdata_d = bus_io.wr_data;
          op_rd_d = bus_io.mem_rd;
          op_wr_d = bus_io.mem_wr;
          cnt_d   = CW'(LAT);
          if (LAT == 0) begin
            state_d = StDone;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
          commit  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (commit) begin
      ready_d = 1'b1;
      err_d   = req_err;
      if (!req_err) begin
        if (req_wr) mem_we = rst_n;
        else        rd_data_d = mem_q[req_idx];
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_rd_q   <= op_rd_d;
      op_wr_q   <= op_wr_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[req_idx] <= req_wdata;
  end

  assign bus_io.rd_data = rd_data_q;
  assign bus_io.ready   = ready_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LAT=2 instance (a) and a LAT=0 instance (b).
module tb_data_mem_responder;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  data_mem_responder_if #(.AW(32)) ifa ();
  data_mem_responder_if #(.AW(32)) ifb ();

  data_mem_responder #(.DEPTH(256), .LAT(2), .AW(32)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ifa)
  );

  data_mem_responder #(.DEPTH(256), .LAT(0), .AW(32)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      ifb.mem_rd = rd; ifb.mem_wr = wr; ifb.addr = a; ifb.wr_data = d;
    end else begin
      ifa.mem_rd = rd; ifa.mem_wr = wr; ifa.addr = a; ifa.wr_data = d;
    end
  endtask

  // Issues one request from an IDLE cycle; returns cycles-to-ready (0 = timeout) and busy cycles.
  task automatic req(input bit sel, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int bsy, output logic e, output logic [31:0] rdat);
    logic rdy, b;
    drive(sel, rd, wr, a, d);
    @(posedge clk);
    lat = 0; bsy = 0; e = 1'b0; rdat = '0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      b   = sel ? ifb.busy : ifa.busy;
      rdy = sel ? ifb.ready : ifa.ready;
      if (b) bsy++;
      if (rdy) begin
        lat  = i;
        e    = sel ? ifb.err : ifa.err;
        rdat = sel ? ifb.rd_data : ifa.rd_data;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  int          lat, bsy;
  logic        e;
  logic [31:0] rdat;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_rd_data", ifa.rd_data, 32'h0);
    check("rst_ready",   {31'h0, ifa.ready}, 32'h0);
    check("rst_busy",    {31'h0, ifa.busy}, 32'h0);
    check("rst_err",     {31'h0, ifa.err}, 32'h0);
    check("rst_b_busy",  {31'h0, ifb.busy}, 32'h0);
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    // Store/load round trip
    req(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, bsy, e, rdat);
    check("st10_lat", lat, 3);
    check("st10_busy", bsy, 3);
    check("st10_err", {31'h0, e}, 32'h0);
    check("st10_rd_data_kept", ifa.rd_data, 32'h0);
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, bsy, e, rdat);
    check("ld10_lat", lat, 3);
    check("ld10_busy", bsy, 3);
    check("ld10_err", {31'h0, e}, 32'h0);
    check("ld10_data", rdat, 32'hDEADBEEF);

    // Back-to-back stores then loads; busy must drop for the IDLE cycle between requests
    for (int i = 0; i < 3; i++) begin
      req(1'b0, 1'b0, 1'b1, 32'(i * 4), 32'h01010101 * (i + 1), lat, bsy, e, rdat);
      check("b2b_st_lat", lat, 3);
      check("b2b_idle_busy", {31'h0, ifa.busy}, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      req(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h0, lat, bsy, e, rdat);
      check("b2b_ld_lat", lat, 3);
      check("b2b_ld_data", rdat, 32'h01010101 * (i + 1));
    end

    // Misaligned load keeps previous rd_data
    req(1'b0, 1'b0, 1'b1, 32'h30, 32'h00001234, lat, bsy, e, rdat);
    req(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, lat, bsy, e, rdat);
    check("ld30_data", rdat, 32'h00001234);
    req(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, lat, bsy, e, rdat);
    check("mis_lat", lat, 3);
    check("mis_err", {31'h0, e}, 32'h1);
    check("mis_rd_data", rdat, 32'h00001234);

    // Out of range and read/write conflict
    req(1'b0, 1'b0, 1'b1, 32'h400, 32'hABCDABCD, lat, bsy, e, rdat);
    check("oor_lat", lat, 3);
    check("oor_err", {31'h0, e}, 32'h1);
    check("oor_rd_data", rdat, 32'h00001234);
    req(1'b0, 1'b0, 1'b1, 32'h20, 32'h77777777, lat, bsy, e, rdat);
    check("st20_err", {31'h0, e}, 32'h0);
    req(1'b0, 1'b1, 1'b1, 32'h20, 32'h99999999, lat, bsy, e, rdat);
    check("conf_lat", lat, 3);
    check("conf_err", {31'h0, e}, 32'h1);
    req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, bsy, e, rdat);
    check("ld20_err", {31'h0, e}, 32'h0);
    check("ld20_data", rdat, 32'h77777777);

    // Reset one cycle after acceptance discards the store
    req(1'b0, 1'b0, 1'b1, 32'h8, 32'h11111111, lat, bsy, e, rdat);
    drive(1'b0, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_busy", {31'h0, ifa.busy}, 32'h0);
    check("rstw_ready", {31'h0, ifa.ready}, 32'h0);
    check("rstw_rd_data", ifa.rd_data, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstw_no_ready", {31'h0, ifa.ready}, 32'h0);
    end
    rst_n = 1'b1;
    req(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, lat, bsy, e, rdat);
    check("rstw_ld8_err", {31'h0, e}, 32'h0);
    check("rstw_ld8_data", rdat, 32'h11111111);

    // LAT=0 instance
    req(1'b1, 1'b0, 1'b1, 32'h0, 32'h5A5A5A5A, lat, bsy, e, rdat);
    check("l0_st_lat", lat, 1);
    check("l0_st_busy", bsy, 1);
    check("l0_st_err", {31'h0, e}, 32'h0);
    req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, lat, bsy, e, rdat);
    check("l0_ld_lat", lat, 1);
    check("l0_ld_data", rdat, 32'h5A5A5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
